// File: rtl/noc_packet_buffer.sv
// Store-and-forward packet buffer for one NoC channel. It holds flits until a whole
// packet is stored, and falls back to cut-through when one packet is larger than the buffer.
module noc_packet_buffer #(
  parameter int unsigned FLIT_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter bit          FULLPACKET = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [FLIT_WIDTH-1:0]    in_flit,
  input  logic                     in_last,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [FLIT_WIDTH-1:0]    out_flit,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     oversize_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  typedef enum logic {NORMAL, DRAIN} state_e;

  logic [FLIT_WIDTH:0] mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]         occ_q, occ_d;
  logic [AW:0]         pkt_cnt_q, pkt_cnt_d;
  state_e              state_q, state_d;
  logic                err_q, err_d;
  logic                live_q;
  logic                wr_en, rd_en, full;
  logic [FLIT_WIDTH:0] head;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    full      = (occ_q == DEPTH_CNT);
    in_ready  = live_q & ~full;
    wr_en     = in_valid & in_ready;
    head      = mem_q[rd_ptr_q];
    out_flit  = head[FLIT_WIDTH-1:0];
    out_last  = head[FLIT_WIDTH];

    if (!FULLPACKET || state_q == DRAIN) out_valid = (occ_q != '0);
    else                                 out_valid = (pkt_cnt_q != '0);
    rd_en = out_valid & out_ready;

    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;

    occ_d = occ_q;
    case ({wr_en, rd_en})
      2'b10:   occ_d = occ_q + (AW+1)'(1);
      2'b01:   occ_d = occ_q - (AW+1)'(1);
      default: occ_d = occ_q;
    endcase

    pkt_cnt_d = pkt_cnt_q;
    case ({wr_en & in_last, rd_en & out_last})
      2'b10:   pkt_cnt_d = pkt_cnt_q + (AW+1)'(1);
      2'b01:   pkt_cnt_d = pkt_cnt_q - (AW+1)'(1);
      default: pkt_cnt_d = pkt_cnt_q;
    endcase

    // A full buffer with no complete packet can only be an oversized packet.
    state_d = state_q;
    err_d   = err_q;
    if (FULLPACKET) begin
      case (state_q)
        NORMAL: if (full && pkt_cnt_q == '0) begin
          state_d = DRAIN;
          err_d   = 1'b1;
        end
        DRAIN:  if (rd_en && out_last) state_d = NORMAL;
        default: state_d = NORMAL;
      endcase
    end

    occupancy    = occ_q;
    oversize_err = err_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      pkt_cnt_q <= '0;
      state_q   <= NORMAL;
      err_q     <= 1'b0;
      live_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      pkt_cnt_q <= pkt_cnt_d;
      state_q   <= state_d;
      err_q     <= err_d;
      live_q    <= 1'b1;
    end
  end

  // NOTE: the storage array is not reset; occupancy and pkt_cnt already mark every entry invalid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {in_last, in_flit};
  end

endmodule

// File: tb/tb_noc_packet_buffer.sv
// Directed bench for noc_packet_buffer: the stimulus pushes expected flits into a
// scoreboard queue and an independent monitor pops and compares every handshake.
module tb_noc_packet_buffer;

  localparam int FW = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [FW-1:0] in_flit = '0;
  logic          in_last = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [FW-1:0] out_flit;
  logic          out_last;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [4:0]    occupancy;
  logic          oversize_err;

  int total = 0;
  int bad   = 0;
  logic [FW:0] sb [$];

  noc_packet_buffer #(.FLIT_WIDTH(FW), .DEPTH(DEPTH), .FULLPACKET(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_flit(in_flit), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .out_flit(out_flit), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .occupancy(occupancy), .oversize_err(oversize_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got %0h expected nothing at %0t", {out_last, out_flit}, $time);
      end else begin
        check("out_data", 64'({out_last, out_flit}), 64'(sb.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [FW-1:0] f, input logic l);
    in_valid = 1'b1;
    in_flit  = f;
    in_last  = l;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back({l, f});
        tick();
        in_valid = 1'b0;
        return;
      end
      tick();
    end
    in_valid = 1'b0;
    check("send_timeout", 64'(0), 64'(1));
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || occupancy != 0) && n < 200) begin
      tick();
      n++;
    end
    check("drain_occ", 64'(occupancy), 64'(0));
    check("drain_sb_empty", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_occ", 64'(occupancy), 64'(0));
    check("rst_err", 64'(oversize_err), 64'(0));
    tick();
    rst = 1'b1;
    tick();
    check("post_rst_in_ready", 64'(in_ready), 64'(1));

    // 3-flit packet: held until the last flit is stored
    out_ready = 1'b1;
    send(32'hA0, 1'b0);
    check("t1_valid_after_a0", 64'(out_valid), 64'(0));
    send(32'hA1, 1'b0);
    check("t1_valid_after_a1", 64'(out_valid), 64'(0));
    send(32'hA2, 1'b1);
    check("t1_valid_after_a2", 64'(out_valid), 64'(1));
    check("t1_occ", 64'(occupancy), 64'(3));
    drain();

    // 16 single-flit packets with the output stalled
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(32'(i), 1'b1);
    check("t2_in_ready_full", 64'(in_ready), 64'(0));
    check("t2_occ_full", 64'(occupancy), 64'(16));
    check("t2_out_valid", 64'(out_valid), 64'(1));
    out_ready = 1'b1;
    tick();
    check("t2_in_ready_after_read", 64'(in_ready), 64'(1));
    check("t2_occ_after_read", 64'(occupancy), 64'(15));
    drain();

    // Occupancy 15 with simultaneous read and write; pointers wrap meanwhile
    out_ready = 1'b0;
    for (int i = 0; i < 15; i++) send(32'h30 + 32'(i), 1'b1);
    check("t3_occ15", 64'(occupancy), 64'(15));
    out_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      send(32'h40 + 32'(i), 1'b1);
      check("t3_occ_steady", 64'(occupancy), 64'(15));
    end
    drain();

    // Oversized 20-flit packet
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(32'h100 + 32'(i), 1'b0);
    check("t4_occ16", 64'(occupancy), 64'(16));
    check("t4_valid_before_drain", 64'(out_valid), 64'(0));
    check("t4_err_before", 64'(oversize_err), 64'(0));
    tick();
    check("t4_err_set", 64'(oversize_err), 64'(1));
    check("t4_valid_drain", 64'(out_valid), 64'(1));
    check("t4_occ16_drain", 64'(occupancy), 64'(16));
    for (int i = 16; i < 20; i++) send(32'h100 + 32'(i), i == 19);
    drain();
    check("t4_err_sticky", 64'(oversize_err), 64'(1));
    // Back in NORMAL: a partial packet must not be visible
    send(32'h200, 1'b0);
    check("t4_normal_hold", 64'(out_valid), 64'(0));
    send(32'h201, 1'b1);
    check("t4_normal_release", 64'(out_valid), 64'(1));
    drain();

    // Reset mid-packet discards stored flits
    out_ready = 1'b0;
    send(32'hB0, 1'b0);
    send(32'hB1, 1'b0);
    rst = 1'b0;
    sb.delete();
    tick();
    check("t5_rst_in_ready", 64'(in_ready), 64'(0));
    check("t5_rst_occ", 64'(occupancy), 64'(0));
    check("t5_rst_err", 64'(oversize_err), 64'(0));
    rst = 1'b1;
    tick();
    send(32'h55, 1'b1);
    check("t5_occ1", 64'(occupancy), 64'(1));
    check("t5_valid", 64'(out_valid), 64'(1));
    drain();

    // Backpressure: head held stable for 5 cycles
    out_ready = 1'b0;
    send(32'hC0, 1'b0);
    send(32'hC1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("t6_valid_hold", 64'(out_valid), 64'(1));
      check("t6_flit_hold", 64'(out_flit), 64'(32'hC0));
      check("t6_last_hold", 64'(out_last), 64'(0));
      tick();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/noc_packet_buffer.md
Name: noc_packet_buffer

Overview:
- Store-and-forward packet buffer for one NoC channel.
- Sits directly downstream of the compute tile's noc_out_flit/last/valid/ready port, one instance per channel, and feeds the NoC router or a bench-side sink.
- Accepts flits whenever space exists and releases a packet only after its last flit is stored, so a stalled tile never leaves a partial packet on the network.
- Includes an oversize fallback so a packet longer than the buffer cannot deadlock it.

Parameters:
- FLIT_WIDTH, 32: flit data width in bits.
- DEPTH, 16: buffer capacity in flits; must be a power of two and at least 2.
- FULLPACKET, 1: 1 = store-and-forward; 0 = plain first-word-fall-through FIFO (cut-through).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_flit  in  FLIT_WIDTH  flit from tile noc_out_flit.
- in_last  in  1  marks the last flit of a packet.
- in_valid  in  1  input flit valid.
- in_ready  out  1  buffer can accept a flit.
- out_flit  out  FLIT_WIDTH  head flit.
- out_last  out  1  head flit is the last of its packet.
- out_valid  out  1  head flit may be consumed.
- out_ready  in  1  downstream accepts the head flit.
- occupancy  out  $clog2(DEPTH)+1  flits currently stored.
- oversize_err  out  1  sticky: a packet exceeding DEPTH was seen.

Behaviour:
- Storage and counters:
  - Circular buffer of DEPTH entries, each FLIT_WIDTH+1 bits (flit plus last).
  - Pointers wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrap modulo DEPTH with no special case.
  - occupancy counts 0..DEPTH.
  - pkt_cnt counts complete packets held, 0..DEPTH.
- Reset (rst = 0, asynchronous):
  - Pointers, occupancy, pkt_cnt and oversize_err go to 0; FSM goes to NORMAL.
  - in_ready = 0 while rst is low, then 1 from the first cycle after deassertion.
  - out_valid = 0; out_flit and out_last are don't-care while out_valid = 0.
  - Asserting reset mid-packet discards all stored flits; no partial packet may appear afterwards.
- Write: in_ready = (occupancy != DEPTH). A write occurs on in_valid & in_ready, storing {in_last, in_flit} at wr_ptr, then wr_ptr += 1.
- Read:
  - out_flit and out_last come combinationally from the entry at rd_ptr.
  - A read occurs on out_valid & out_ready, then rd_ptr += 1.
- out_valid:
  - FULLPACKET = 0: out_valid = (occupancy != 0).
  - FULLPACKET = 1, state NORMAL: out_valid = (pkt_cnt != 0).
  - FULLPACKET = 1, state DRAIN: out_valid = (occupancy != 0).
- Latency:
  - A flit written in cycle N is visible at the output in cycle N+1 at the earliest.
  - FULLPACKET = 1: out_valid for a packet rises in the cycle after its last flit is written. A write in the same cycle does not bypass to the output.
- Counter updates:
  - Write and read in the same cycle: occupancy unchanged.
  - pkt_cnt +1 on a write with in_last = 1; -1 on a read with out_last = 1; both in the same cycle leave it unchanged.
  - A write is legal when occupancy = DEPTH-1 together with a read; it is not legal when full, even if a read happens in the same cycle (in_ready depends only on occupancy).
- FSM (only when FULLPACKET = 1):
  - NORMAL -> DRAIN when occupancy == DEPTH and pkt_cnt == 0 (oversized packet fills the buffer). oversize_err is set to 1 at that transition.
  - DRAIN: cut-through for the oversized packet.
  - DRAIN -> NORMAL on a read with out_last = 1.
  - oversize_err stays 1 until reset.
  - When FULLPACKET = 0, the FSM is held in NORMAL and oversize_err stays 0.
- Backpressure: out_flit and out_last must remain stable while out_valid = 1 and out_ready = 0.
- in_flit content is never inspected; in_last alone delimits packets.
- Single-flit packets (in_last = 1 on the first flit) are legal.

Test Plan:
- Reset, then write a 3-flit packet 0xA0, 0xA1, 0xA2 (last on 0xA2) with out_ready = 1.
  -> out_valid stays 0 until the cycle after 0xA2 is written, then 0xA0, 0xA1, 0xA2 leave on consecutive cycles with out_last only on 0xA2; occupancy returns to 0.
- With out_ready = 0, write 16 single-flit packets 0x00..0x0F.
  -> in_ready drops after the 16th write and occupancy = 16. Then out_ready = 1 drains 0x00..0x0F in order and in_ready returns to 1 after the first read.
- Occupancy 15 with a complete packet at the head; drive a simultaneous read and write.
  -> occupancy stays 15, pointers wrap from 15 to 0, and data order is preserved.
- Write a 20-flit packet (last on flit 20) with DEPTH = 16 and out_ready = 1.
  -> at occupancy 16, oversize_err = 1 and out_valid = 1 (DRAIN). All 20 flits emerge in order, the FSM returns to NORMAL after flit 20, and oversize_err remains 1.
- Assert rst mid-packet after 2 of 4 flits are written, release it, then send a 1-flit packet 0x55 (last).
  -> only 0x55 emerges and occupancy is 1 before the read.
- Hold out_ready = 0 for 5 cycles with a packet at the head.
  -> out_flit and out_last are stable and out_valid stays 1 throughout.
